ysyx_220053_mem_arbiter: RTL and testbench
==========================================

Name: ysyx_220053_mem_arbiter

Overview:
- Two-requester, single-outstanding arbiter that shares one memory port between master 0 (IFU fetch) and master 1 (LSU load/store).
- Each request is latched on acceptance and replayed to the slave port. The slave response is returned to the granted master only.
- Round-robin fairness on simultaneous requests. A response watchdog returns an error response if the slave never answers.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width (multiple of 8)
- TIMEOUT, 255, max cycles waited in RESP before forced error response (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m0_req_valid  in  1  master0 request
- m0_req_ready  out  1  master0 request accepted this cycle
- m0_addr  in  ADDR_W  master0 address
- m0_wen  in  1  master0 write enable
- m0_wdata  in  DATA_W  master0 write data
- m0_wmask  in  DATA_W/8  master0 byte mask
- m0_resp_valid  out  1  master0 response pulse
- m0_resp_err  out  1  master0 response timed out
- m1_*  same set as m0_*  master1
- m_rdata  out  DATA_W  read data, shared by both masters; qualified by mX_resp_valid
- s_req_valid  out  1  slave request
- s_req_ready  in  1  slave accepts
- s_addr  out  ADDR_W  latched address
- s_wen  out  1  latched write enable
- s_wdata  out  DATA_W  latched write data
- s_wmask  out  DATA_W/8  latched mask
- s_resp_valid  in  1  slave response
- s_rdata  in  DATA_W  slave read data

Behaviour:
- Reset is synchronous and active-high; the port is driven by clk.
- Reset values:
  - state=IDLE, last=1 (master0 wins the first tie), grant=0, wait counter=0.
  - All valid/ready/err outputs are 0.
  - s_addr/s_wen/s_wdata/s_wmask registers are 0.
- IDLE:
  - mX_req_ready=1 combinationally for exactly the selected master, and only when that master's req_valid=1.
  - Selection when one valid: that master. When both valid: the master != last.
  - On acceptance: latch addr/wen/wdata/wmask and grant, then go to REQ.
  - No acceptance without valid.
- REQ:
  - s_req_valid=1 with the latched fields; these are stable until the handshake.
  - When s_req_ready=1: go to RESP and clear the counter.
  - s_resp_valid is ignored in REQ.
- RESP:
  - Counter increments each cycle.
  - If s_resp_valid=1: m[grant]_resp_valid=1 combinationally and m_rdata=s_rdata, resp_err=0. Then last<=grant and go to IDLE.
  - Else if counter==TIMEOUT-1: m[grant]_resp_valid=1, resp_err=1, m_rdata=0. Then last<=grant and go to IDLE.
  - s_resp_valid takes priority over timeout in the same cycle.
- The non-granted master never sees resp_valid or req_ready during a transaction.
- Masters hold a request while ready=0, and may change it freely after acceptance.
- Latency: accept at cycle N, s_req_valid at N+1. Minimum response at N+2 (slave ready at N+1, responds at N+2).
- Back-to-back: a new request can be accepted in the cycle after resp_valid (IDLE). Throughput is at most 1 transaction per 3 cycles.
- Stray s_resp_valid in IDLE/REQ is dropped, with no output effect.
- Reset mid-transaction: the transaction is abandoned, no response is issued, all registers return to reset values next cycle.
- Writes also produce a response; rdata is don't-care for writes but is still forwarded.

Test Plan:
- Single read: m0 req addr 0x80000000 wen=0 → m0_req_ready same cycle; s_req_valid next cycle with s_addr=0x80000000; slave returns 0x1122334455667788 → m0_resp_valid 1 cycle with m_rdata=0x1122334455667788; m1 outputs stay 0.
- Tie fairness: both valid continuously, slave always ready and responding after 1 cycle → grants alternate m0,m1,m0,m1 over 4 transactions, starting with m0 after reset.
- Backpressure: s_req_ready=0 for 5 cycles with m1 write addr 0x10, wdata 0xAB, wmask 0x01 → s_req_valid and all s_* fields held stable for all 5 cycles; m0 request raised meanwhile gets no ready until after the m1 response.
- Timeout: TIMEOUT=4, slave never responds → m0_resp_valid=1, m0_resp_err=1, m_rdata=0 on the 4th RESP cycle; next request accepted in the following cycle.
- Response and timeout in the same cycle: s_resp_valid on the last RESP cycle → err=0, rdata=s_rdata.
- Reset in RESP state: assert rst 1 cycle, then the slave responds → no mX_resp_valid; state IDLE; next tie goes to m0.

Source files
------------

// File: rtl/ysyx_220053_mem_arbiter.sv
// Two-master, single-outstanding memory arbiter.
// Master 0 (IFU) and master 1 (LSU) share one slave port. An accepted request
// is latched and replayed to the slave. The response is routed back to the
// granted master only. Simultaneous requests are served round-robin, and a
// watchdog answers with an error if the slave stays silent for TIMEOUT cycles.
module ysyx_220053_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    // master 0 (instruction fetch)
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic                m0_wen,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wmask,
    output logic                m0_resp_valid,
    output logic                m0_resp_err,
    // master 1 (load/store)
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic                m1_wen,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    output logic                m1_resp_valid,
    output logic                m1_resp_err,
    // shared read data, qualified by mX_resp_valid
    output logic [DATA_W-1:0]   m_rdata,
    // slave port
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_wen,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic                s_resp_valid,
    input  logic [DATA_W-1:0]   s_rdata
);

    // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t            state;
    logic              last;   // master served most recently; loses the next tie
    logic              grant;  // master owning the current transaction
    logic [CNT_W-1:0]  cnt;

    logic              sel;
    logic              accept;
    logic              resp_fire;
    logic              resp_timeout;
    logic              resp_done;

    // Arbitration, handshakes and response routing are decoded from the current state.
    always_comb begin
        sel          = (m0_req_valid && m1_req_valid) ? ~last : m1_req_valid;
        accept       = (state == IDLE) && (m0_req_valid || m1_req_valid);
        m0_req_ready = accept && !sel;
        m1_req_ready = accept && sel;

        // a real response wins over the watchdog firing in the same cycle
        resp_fire    = (state == RESP) && s_resp_valid;
        resp_timeout = (state == RESP) && !s_resp_valid && (cnt == CNT_LAST);
        resp_done    = resp_fire || resp_timeout;

        m0_resp_valid = resp_done && !grant;
        m1_resp_valid = resp_done && grant;
        m0_resp_err   = resp_timeout && !grant;
        m1_resp_err   = resp_timeout && grant;
        m_rdata       = resp_fire ? s_rdata : '0;

        s_req_valid   = (state == REQ);
    end

    // Transaction FSM: latch the winning request, replay it, wait for the answer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            grant   <= 1'b0;
            cnt     <= '0;
            s_addr  <= '0;
            s_wen   <= 1'b0;
            s_wdata <= '0;
            s_wmask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant   <= sel;
                        s_addr  <= sel ? m1_addr  : m0_addr;
                        s_wen   <= sel ? m1_wen   : m0_wen;
                        s_wdata <= sel ? m1_wdata : m0_wdata;
                        s_wmask <= sel ? m1_wmask : m0_wmask;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (s_req_ready) begin
                        cnt   <= '0;
                        state <= RESP;
                    end
                end
                RESP: begin
                    // wrap at the last count is harmless: the FSM leaves RESP then
                    cnt <= cnt + CNT_W'(1);
                    if (resp_done) begin
                        last  <= grant;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
// Self-checking bench for ysyx_220053_mem_arbiter (TIMEOUT=4).
// Expected responses are queued when a request is accepted and popped when
// the DUT raises a response valid.
module tb_ysyx_220053_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid, m0_resp_err;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [MW-1:0] m0_wmask;
    logic          m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_err;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [MW-1:0] m1_wmask;
    logic [DW-1:0] m_rdata;
    logic          s_req_valid, s_req_ready, s_wen, s_resp_valid;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [MW-1:0] s_wmask;

    ysyx_220053_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_resp_valid(m0_resp_valid), .m0_resp_err(m0_resp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_resp_valid(m1_resp_valid), .m1_resp_err(m1_resp_err),
        .m_rdata(m_rdata),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
        .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_resp_valid(s_resp_valid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            mst;
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        int            rdy_dly;
        int            rsp_dly;
        logic [DW-1:0] rdata;
        bit            exp_err;
        logic [DW-1:0] exp_rd;
    } vec_t;

    typedef struct {
        bit            mst;
        bit            err;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // response scoreboard and arbitration exclusivity, called once per cycle
    task automatic mon();
        exp_t e;
        chk("ready_exclusive", m0_req_ready & m1_req_ready, 0);
        if (m0_resp_valid || m1_resp_valid) begin
            if (q.size() == 0) begin
                chk("stray_resp", 1, 0);
            end else begin
                e = q.pop_front();
                chk("resp_both", m0_resp_valid & m1_resp_valid, 0);
                chk("resp_mst", m1_resp_valid, e.mst);
                chk("resp_err", e.mst ? m1_resp_err : m0_resp_err, e.err);
                chk("resp_other_err", e.mst ? m0_resp_err : m1_resp_err, 0);
                chk("resp_rdata", m_rdata, e.rd);
            end
        end
    endtask

    task automatic drive_m(input bit mst, input logic v, input logic [AW-1:0] a,
                           input logic w, input logic [DW-1:0] d, input logic [MW-1:0] m);
        if (mst) begin
            m1_req_valid = v; m1_addr = a; m1_wen = w; m1_wdata = d; m1_wmask = m;
        end else begin
            m0_req_valid = v; m0_addr = a; m0_wen = w; m0_wdata = d; m0_wmask = m;
        end
    endtask

    // Wait (bounded) for the given master's ready in IDLE, then queue its response.
    task automatic accept(input bit mst, input logic [DW-1:0] exp_rd, input bit exp_err,
                          input int max_wait, output int waited);
        exp_t e;
        waited = 0;
        #1;
        mon();
        while (!(mst ? m1_req_ready : m0_req_ready) && waited < max_wait) begin
            step();
            #1;
            mon();
            waited++;
        end
        chk("accept_ready", mst ? m1_req_ready : m0_req_ready, 1);
        chk("accept_other", mst ? m0_req_ready : m1_req_ready, 0);
        chk("idle_no_sreq", s_req_valid, 0);
        e.mst = mst;
        e.err = exp_err;
        e.rd  = exp_err ? '0 : exp_rd;
        q.push_back(e);
        step();
    endtask

    // Play the slave from the first REQ cycle until the FSM is back in IDLE.
    task automatic serve(input bit mst, input int rdy_dly, input int rsp_dly,
                         input logic [AW-1:0] ea, input logic ew, input logic [DW-1:0] ed,
                         input logic [MW-1:0] em, input logic [DW-1:0] rd);
        int exp_k;
        exp_k = (rsp_dly < TO) ? rsp_dly : TO - 1;
        for (int c = 0; c <= rdy_dly; c++) begin
            s_req_ready = (c == rdy_dly);
            // a stray slave response during REQ must be ignored
            s_resp_valid = (c == 0);
            s_rdata      = 64'hBAD0_BAD0_BAD0_BAD0;
            #1;
            mon();
            chk("req_valid", s_req_valid, 1);
            chk("req_addr", s_addr, ea);
            chk("req_wen", s_wen, ew);
            chk("req_wdata", s_wdata, ed);
            chk("req_wmask", s_wmask, em);
            chk("req_no_ready", m0_req_ready | m1_req_ready, 0);
            chk("req_no_resp", m0_resp_valid | m1_resp_valid, 0);
            step();
            s_resp_valid = 1'b0;
        end
        s_req_ready = 1'b0;
        for (int k = 0; k < TO; k++) begin
            if (k == rsp_dly) begin
                s_resp_valid = 1'b1;
                s_rdata      = rd;
            end
            #1;
            mon();
            chk("resp_timing", mst ? m1_resp_valid : m0_resp_valid, k == exp_k);
            chk("resp_no_ready", m0_req_ready | m1_req_ready, 0);
            chk("resp_no_sreq", s_req_valid, 0);
            step();
            s_resp_valid = 1'b0;
            if (k == exp_k) break;
        end
        chk("resp_seen", q.size(), 0);
        q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0] = '{0, 32'h8000_0000, 1'b0, 64'h0, 8'h00, 0, 0, 64'h1122334455667788, 0, 64'h1122334455667788};
        vecs[1] = '{1, 32'h0000_2000, 1'b1, 64'h0123456789ABCDEF, 8'hF0, 1, 1, 64'h5A5A, 0, 64'h5A5A};
        vecs[2] = '{0, 32'h0000_0100, 1'b0, 64'h0, 8'h00, 2, 3, 64'hCAFE0003, 0, 64'hCAFE0003};
        vecs[3] = '{0, 32'h0000_0200, 1'b0, 64'h0, 8'h00, 0, 9, 64'hFFFF, 1, 64'h0};
        vecs[4] = '{1, 32'h0000_0300, 1'b0, 64'h0, 8'hFF, 0, 2, 64'hDEADBEEFCAFEF00D, 0, 64'hDEADBEEFCAFEF00D};
        vecs[5] = '{1, 32'h0000_0400, 1'b1, 64'h11, 8'h01, 3, 9, 64'h1234, 1, 64'h0};

        rst = 1'b1;
        drive_m(0, 0, '0, 0, '0, '0);
        drive_m(1, 0, '0, 0, '0, '0);
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = '0;
        step(); step();
        #1;
        chk("rst_sreq", s_req_valid, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_swen", s_wen, 0);
        chk("rst_swdata", s_wdata, 0);
        chk("rst_swmask", s_wmask, 0);
        chk("rst_resp", {m0_resp_valid, m0_resp_err, m1_resp_valid, m1_resp_err}, 0);
        rst = 1'b0;
        step();

        // both masters request continuously: grants must alternate from m0
        drive_m(0, 1, 32'h0000_A000, 0, '0, '0);
        drive_m(1, 1, 32'h0000_B000, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            bit exp_m;
            exp_m = bit'(i % 2);
            #1;
            chk("tie_m0_ready", m0_req_ready, exp_m == 0);
            chk("tie_m1_ready", m1_req_ready, exp_m == 1);
            accept(exp_m, 64'h1000 + 64'(i), 0, 0, w);
            serve(exp_m, 0, 0, exp_m ? 32'h0000_B000 : 32'h0000_A000, 0, '0, '0, 64'h1000 + 64'(i));
        end
        drive_m(0, 0, '0, 0, '0, '0);
        drive_m(1, 0, '0, 0, '0, '0);
        step();

        // single-master vectors, including timeout and response-on-last-cycle
        for (int i = 0; i < 6; i++) begin
            drive_m(vecs[i].mst, 1, vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].wmask);
            accept(vecs[i].mst, vecs[i].exp_rd, vecs[i].exp_err, 3, w);
            chk("vec_accept_lat", w, 0);
            drive_m(vecs[i].mst, 0, '0, 0, '0, '0);
            serve(vecs[i].mst, vecs[i].rdy_dly, vecs[i].rsp_dly, vecs[i].addr, vecs[i].wen,
                  vecs[i].wdata, vecs[i].wmask, vecs[i].rdata);
        end

        // slave backpressure on an m1 write while m0 waits
        drive_m(1, 1, 32'h10, 1, 64'hAB, 8'h01);
        accept(1, 64'h77, 0, 3, w);
        drive_m(1, 0, '0, 0, '0, '0);
        drive_m(0, 1, 32'h40, 0, '0, '0);
        serve(1, 5, 1, 32'h10, 1, 64'hAB, 8'h01, 64'h77);
        accept(0, 64'h4040, 0, 0, w);
        chk("bp_m0_after", w, 0);
        drive_m(0, 0, '0, 0, '0, '0);
        serve(0, 0, 0, 32'h40, 0, '0, '0, 64'h4040);

        // reset while waiting for a response abandons the transaction
        drive_m(0, 1, 32'h500, 0, '0, '0);
        accept(0, 64'h999, 0, 3, w);
        drive_m(0, 0, '0, 0, '0, '0);
        s_req_ready = 1'b1;
        #1;
        mon();
        step();
        s_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        mon();
        step();
        rst = 1'b0;
        q.delete();
        s_resp_valid = 1'b1;
        s_rdata = 64'h999;
        #1;
        mon();
        chk("rstmid_m0_resp", m0_resp_valid, 0);
        chk("rstmid_m1_resp", m1_resp_valid, 0);
        chk("rstmid_sreq", s_req_valid, 0);
        step();
        s_resp_valid = 1'b0;
        drive_m(0, 1, 32'h600, 0, '0, '0);
        drive_m(1, 1, 32'h700, 0, '0, '0);
        accept(0, 64'h66, 0, 0, w);
        chk("rstmid_tie_m0", w, 0);
        drive_m(0, 0, '0, 0, '0, '0);
        drive_m(1, 0, '0, 0, '0, '0);
        serve(0, 0, 0, 32'h600, 0, '0, '0, 64'h66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
